// File: rtl/edge_sched_pkg.sv
// rtl/edge_sched_pkg.sv - shared types and round-robin helper for edge_event_scheduler
package edge_sched_pkg;

  // Scheduler FSM: nothing offered / one event offered to the consumer
  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } sched_state_t;

  localparam int unsigned MAX_NCH = 16;

  // First set request bit searching upward from last+1, wrapping at n.
  // Returns last when no bit is set; callers only use the result when req != 0.
  function automatic logic [3:0] rr_next(input logic [15:0] req,
                                         input logic [3:0]  last,
                                         input int unsigned n);
    logic [3:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_NCH; k++) begin
      idx = 32'(last) + k;
      if (idx >= n) idx = idx - n;
      if (!found && (k <= n) && req[idx[3:0]]) begin
        pick  = idx[3:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/edge_event_sync.sv
// rtl/edge_event_sync.sv - one channel: 2-flop synchroniser, history flop, registered falling-edge pulse
module edge_event_sync (
  input  logic dstclk,
  input  logic dstresetn,
  input  logic srcdata,
  output logic pulse
);

  logic sync_q1;
  logic sync_q2;
  logic hist_q;

  // Synchronise the async level, keep one cycle of history, flag a 1->0 step
  always_ff @(posedge dstclk or negedge dstresetn) begin
    if (!dstresetn) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      hist_q  <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_q1 <= srcdata;
      sync_q2 <= sync_q1;
      hist_q  <= sync_q2;
      pulse   <= hist_q & ~sync_q2;
    end
  end

endmodule

// File: rtl/edge_event_scheduler.sv
// rtl/edge_event_scheduler.sv - falling-edge event collector and round-robin serialiser; EDGE_SCHED_TIMESTAMP_EN adds evtTime
module edge_event_scheduler
  import edge_sched_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int IDXW = 2
`ifdef EDGE_SCHED_TIMESTAMP_EN
  ,
  parameter int TSW  = 16
`endif
) (
  input  logic            dstclk,
  input  logic            dstresetn,
  input  logic [NCH-1:0]  srcdata,
  input  logic [NCH-1:0]  chanEn,
  input  logic [NCH-1:0]  ovfClear,
  output logic            evtValid,
  input  logic            evtReady,
  output logic [IDXW-1:0] evtChan,
  output logic [NCH-1:0]  ovfFlag,
  output logic            busy
`ifdef EDGE_SCHED_TIMESTAMP_EN
  ,
  output logic [TSW-1:0]  evtTime
`endif
);

  logic [NCH-1:0]  pulse;
  logic [NCH-1:0]  pending_q;
  logic [NCH-1:0]  grant_oh;
  logic [NCH-1:0]  ovf_set;
  logic [IDXW-1:0] last_grant_q;
  logic [IDXW-1:0] grant_idx;
  logic            grant_fire;
  sched_state_t    state_q;
  sched_state_t    state_d;

  for (genvar i = 0; i < NCH; i++) begin : g_sync
    edge_event_sync u_sync (
      .dstclk    (dstclk),
      .dstresetn (dstresetn),
      .srcdata   (srcdata[i]),
      .pulse     (pulse[i])
    );
  end

  assign grant_idx = IDXW'(rr_next(16'(pending_q), 4'(last_grant_q), NCH));
  assign grant_oh  = grant_fire ? ({{(NCH-1){1'b0}}, 1'b1} << grant_idx) : '0;
  // A pulse on the channel being granted is a new event, not a lost one
  assign ovf_set   = pulse & chanEn & pending_q & ~grant_oh;

  // FSM state register
  always_ff @(posedge dstclk or negedge dstresetn) begin
    if (!dstresetn) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state and grant decision; a handshake with work left re-grants at once
  always_comb begin
    state_d    = state_q;
    grant_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          grant_fire = 1'b1;
          state_d    = OFFER;
        end
      end
      OFFER: begin
        if (evtReady) begin
          if (|pending_q) grant_fire = 1'b1;
          else            state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state so reset removes the offer immediately
  always_comb begin
    evtValid = (state_q == OFFER);
    busy     = (|pending_q) | evtValid;
  end

  // Pending bits: set beats grant-clear, disabled channels are flushed
  always_ff @(posedge dstclk or negedge dstresetn) begin
    if (!dstresetn) pending_q <= '0;
    else            pending_q <= chanEn & ((pending_q & ~grant_oh) | pulse);
  end

  // Sticky overflow flags: a new overflow wins over a clear in the same cycle
  always_ff @(posedge dstclk or negedge dstresetn) begin
    if (!dstresetn) ovfFlag <= '0;
    else            ovfFlag <= ovf_set | (ovfFlag & ~ovfClear);
  end

  // Offered channel and round-robin pointer, updated on every grant
  always_ff @(posedge dstclk or negedge dstresetn) begin
    if (!dstresetn) begin
      evtChan      <= '0;
      last_grant_q <= IDXW'(NCH - 1);
    end else if (grant_fire) begin
      evtChan      <= grant_idx;
      last_grant_q <= grant_idx;
    end
  end

`ifdef EDGE_SCHED_TIMESTAMP_EN
  logic [TSW-1:0] ts_cnt;
  logic [TSW-1:0] ts_cap [NCH];

  // Free-running time base, wraps naturally
  always_ff @(posedge dstclk or negedge dstresetn) begin
    if (!dstresetn) ts_cnt <= '0;
    else            ts_cnt <= ts_cnt + 1'b1;
  end

  // Capture time whenever a channel becomes (or stays, via set-beats-clear) freshly pending
  always_ff @(posedge dstclk or negedge dstresetn) begin
    if (!dstresetn) begin
      for (int i = 0; i < NCH; i++) ts_cap[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (pulse[i] && chanEn[i] && (!pending_q[i] || grant_oh[i])) ts_cap[i] <= ts_cnt;
      end
    end
  end

  // Offered timestamp follows the grant and is otherwise held
  always_ff @(posedge dstclk or negedge dstresetn) begin
    if (!dstresetn)      evtTime <= '0;
    else if (grant_fire) evtTime <= ts_cap[grant_idx];
  end
`endif

endmodule

// File: tb/tb_edge_event_scheduler.sv
// tb/tb_edge_event_scheduler.sv - scoreboard bench for edge_event_scheduler
module tb_edge_event_scheduler;

  logic       dstclk = 1'b0;
  logic       dstresetn;
  logic [3:0] srcdata;
  logic [3:0] chanEn;
  logic [3:0] ovfClear;
  logic       evtValid;
  logic       evtReady;
  logic [1:0] evtChan;
  logic [3:0] ovfFlag;
  logic       busy;
`ifdef EDGE_SCHED_TIMESTAMP_EN
  logic [15:0] evtTime;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int mon_exp;
  int cyc;

  always #5 dstclk = ~dstclk;

  edge_event_scheduler dut (
    .dstclk    (dstclk),
    .dstresetn (dstresetn),
    .srcdata   (srcdata),
    .chanEn    (chanEn),
    .ovfClear  (ovfClear),
    .evtValid  (evtValid),
    .evtReady  (evtReady),
    .evtChan   (evtChan),
    .ovfFlag   (ovfFlag),
    .busy      (busy)
`ifdef EDGE_SCHED_TIMESTAMP_EN
    ,
    .evtTime   (evtTime)
`endif
  );

  // edges since reset release; equals the expected time-base value after each edge
  always @(posedge dstclk or negedge dstresetn) begin
    if (!dstresetn) cyc <= 0;
    else            cyc <= cyc + 1;
  end

  // scoreboard: every accepted event must match the next expected channel
  always @(negedge dstclk) begin
    if (dstresetn === 1'b1 && evtValid === 1'b1 && evtReady === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: evtChan=%0d accepted, required no event", evtChan);
      end else begin
        mon_exp = exp_q.pop_front();
        if (evtChan !== mon_exp[1:0]) begin
          n_fail++;
          $display("FAIL sb_chan: evtChan=%0d, required %0d", evtChan, mon_exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge dstclk);
    #1;
  endtask

  task automatic apply_reset();
    dstresetn = 1'b0;
    evtReady  = 1'b0;
    ovfClear  = 4'h0;
    chanEn    = 4'hF;
    srcdata   = 4'hF;
    exp_q.delete();
    tick(2);
    dstresetn = 1'b1;
    tick(4);
  endtask

  task automatic wait_valid(input int bound, output int lat);
    lat = 0;
    for (int t = 1; t <= bound; t++) begin
      tick(1);
      if (evtValid === 1'b1) begin
        lat = t;
        break;
      end
    end
  endtask

  task automatic drain(input string name);
    evtReady = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (exp_q.size() == 0 && busy === 1'b0 && evtValid === 1'b0) break;
      tick(1);
    end
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d events outstanding busy=%b, required 0 and 0", name, exp_q.size(), busy);
    end
    evtReady = 1'b0;
  endtask

  task automatic test_reset();
    dstresetn = 1'b0;
    evtReady  = 1'b0;
    ovfClear  = 4'h0;
    chanEn    = 4'hF;
    srcdata   = 4'hF;
    #1;
    n_checks++;
    if ({evtValid, evtChan, ovfFlag, busy} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b chan=%0d ovf=%b busy=%b, required all 0", evtValid, evtChan, ovfFlag, busy);
    end
  endtask

  task automatic test_single_event();
    int lat;
    apply_reset();
    srcdata[2] = 1'b0;
    exp_q.push_back(2);
    wait_valid(10, lat);
    n_checks++;
    if (lat != 5) begin
      n_fail++;
      $display("FAIL single_latency: evtValid after %0d edges, required 5", lat);
    end
    n_checks++;
    if (evtChan !== 2'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_chan: evtChan=%0d busy=%b, required 2 and 1", evtChan, busy);
    end
    for (int t = 0; t < 3; t++) begin
      tick(1);
      n_checks++;
      if (evtValid !== 1'b1 || evtChan !== 2'd2) begin
        n_fail++;
        $display("FAIL single_hold: valid=%b chan=%0d, required 1 and 2", evtValid, evtChan);
      end
    end
    evtReady = 1'b1;
    tick(1);
    evtReady = 1'b0;
    n_checks++;
    if (evtValid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: valid=%b busy=%b, required 0 and 0", evtValid, busy);
    end
    srcdata[2] = 1'b1;
  endtask

  task automatic test_back_to_back();
    int lat;
    apply_reset();
    evtReady = 1'b1;
    srcdata  = 4'h0;
    for (int c = 0; c < 4; c++) exp_q.push_back(c);
    wait_valid(10, lat);
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (evtValid !== 1'b1 || evtChan !== 2'(c)) begin
        n_fail++;
        $display("FAIL b2b_seq: valid=%b chan=%0d, required 1 and %0d", evtValid, evtChan, c);
      end
      tick(1);
    end
    n_checks++;
    if (evtValid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: evtValid=%b, required 0", evtValid);
    end
    drain("b2b");
  endtask

  task automatic test_overflow();
    apply_reset();
    srcdata[0] = 1'b0;
    exp_q.push_back(0);
    tick(6);
    srcdata[1] = 1'b0;
    exp_q.push_back(1);
    tick(3);
    srcdata[1] = 1'b1;
    tick(3);
    srcdata[1] = 1'b0;
    tick(6);
    n_checks++;
    if (ovfFlag !== 4'b0010 || evtChan !== 2'd0) begin
      n_fail++;
      $display("FAIL ovf_set: ovfFlag=%b chan=%0d, required 0010 and 0", ovfFlag, evtChan);
    end
    ovfClear = 4'b0010;
    tick(1);
    ovfClear = 4'h0;
    n_checks++;
    if (ovfFlag !== 4'b0000) begin
      n_fail++;
      $display("FAIL ovf_clear: ovfFlag=%b, required 0000", ovfFlag);
    end
    srcdata[1] = 1'b1;
    tick(4);
    srcdata[1] = 1'b0;
    tick(3);
    ovfClear = 4'b0010;
    tick(1);
    ovfClear = 4'h0;
    n_checks++;
    if (ovfFlag !== 4'b0010) begin
      n_fail++;
      $display("FAIL ovf_set_wins: ovfFlag=%b, required 0010", ovfFlag);
    end
    tick(2);
    n_checks++;
    if (ovfFlag !== 4'b0010) begin
      n_fail++;
      $display("FAIL ovf_sticky: ovfFlag=%b, required 0010", ovfFlag);
    end
    drain("ovf");
  endtask

  task automatic test_chan_disable();
    apply_reset();
    chanEn     = 4'b1110;
    srcdata[0] = 1'b0;
    tick(8);
    n_checks++;
    if (evtValid !== 1'b0 || ovfFlag !== 4'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dis_drop: valid=%b ovf=%b busy=%b, required 0 0000 0", evtValid, ovfFlag, busy);
    end
    srcdata[0] = 1'b1;
    tick(4);
    srcdata[1] = 1'b0;
    exp_q.push_back(1);
    tick(6);
    n_checks++;
    if (evtValid !== 1'b1 || evtChan !== 2'd1) begin
      n_fail++;
      $display("FAIL dis_offer: valid=%b chan=%0d, required 1 and 1", evtValid, evtChan);
    end
    chanEn     = 4'hF;
    srcdata[0] = 1'b0;
    tick(5);
    chanEn = 4'b1110;
    tick(1);
    chanEn = 4'hF;
    drain("dis");
    n_checks++;
    if (ovfFlag !== 4'h0) begin
      n_fail++;
      $display("FAIL dis_ovf: ovfFlag=%b, required 0000", ovfFlag);
    end
  endtask

  task automatic test_reset_mid_offer();
    int lat;
    apply_reset();
    srcdata = 4'b1000;
    tick(6);
    n_checks++;
    if (evtValid !== 1'b1 || evtChan !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_pre: valid=%b chan=%0d, required 1 and 0", evtValid, evtChan);
    end
    dstresetn = 1'b0;
    #1;
    n_checks++;
    if (evtValid !== 1'b0 || busy !== 1'b0 || evtChan !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_async: valid=%b busy=%b chan=%0d, required 0 0 0", evtValid, busy, evtChan);
    end
    tick(2);
    srcdata   = 4'hF;
    dstresetn = 1'b1;
    tick(10);
    n_checks++;
    if (evtValid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_discard: valid=%b busy=%b, required 0 and 0", evtValid, busy);
    end
    srcdata = 4'b0110;
    exp_q.push_back(0);
    exp_q.push_back(3);
    wait_valid(10, lat);
    n_checks++;
    if (evtValid !== 1'b1 || evtChan !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_first_grant: valid=%b chan=%0d, required 1 and 0", evtValid, evtChan);
    end
    drain("rst");
  endtask

`ifdef EDGE_SCHED_TIMESTAMP_EN
  task automatic test_timestamp();
    int lat;
    apply_reset();
    for (int g = 0; g < 70000; g++) begin
      if (cyc == 16'hFFFB) break;
      tick(1);
    end
    srcdata[2] = 1'b0;
    exp_q.push_back(2);
    wait_valid(10, lat);
    n_checks++;
    if (evtValid !== 1'b1 || evtTime !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL ts_capture: valid=%b evtTime=%h, required 1 and fffe", evtValid, evtTime);
    end
    for (int t = 0; t < 5; t++) begin
      tick(1);
      n_checks++;
      if (evtTime !== 16'hFFFE || evtChan !== 2'd2) begin
        n_fail++;
        $display("FAIL ts_hold: evtTime=%h chan=%0d, required fffe and 2", evtTime, evtChan);
      end
    end
    drain("ts");
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_event();
    test_back_to_back();
    test_overflow();
    test_chan_disable();
    test_reset_mid_offer();
`ifdef EDGE_SCHED_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
